riscv_hwloop_sequencer: RTL and testbench
=========================================

RISCV_HWLOOP_SEQUENCER -- requirements
Module: riscv_hwloop_sequencer

Interface
REQ-001 The block SHALL have parameter N_REGS, default 2, meaning the number of hardware-loop register sets.
REQ-002 The block SHALL have parameter N_REG_BITS, default $clog2(N_REGS), meaning the width of the loop-index fields.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port current_pc_i, input, 32, the PC of the instruction in ID.
REQ-006 The block SHALL have port pc_valid_i, input, 1, the ID instruction retires this cycle.
REQ-007 The block SHALL have port hwlp_start_addr_i, input, N_REGS x 32, the loop start addresses.
REQ-008 The block SHALL have port hwlp_end_addr_i, input, N_REGS x 32, the loop end addresses.
REQ-009 The block SHALL have port hwlp_counter_i, input, N_REGS x 32, the loop counters.
REQ-010 The block SHALL have port hwlp_cnt_we_i, input, 1, a counter write this cycle.
REQ-011 The block SHALL have port hwlp_regid_i, input, N_REG_BITS, the target of that counter write.
REQ-012 The block SHALL have port flush_i, input, 1, a branch/exception/debug flush.
REQ-013 The block SHALL have port fetch_ack_i, input, 1, the prefetcher accepted the jump target.
REQ-014 The block SHALL have port hwlp_dec_cnt_o, output, N_REGS, a one-hot decrement strobe to the loop registers.
REQ-015 The block SHALL have port hwlp_jump_o, output, 1, a jump request to the prefetcher.
REQ-016 The block SHALL have port hwlp_targ_addr_o, output, 32, the jump target, valid while hwlp_jump_o=1.
REQ-017 The block SHALL have port hwlp_stall_o, output, 1, which holds ID while a jump is outstanding.
REQ-018 The block SHALL have port hwlp_active_o, output, N_REGS, where bit k=1 iff hwlp_counter_i[k]!=0.

Function
REQ-019 The block SHALL compute match[k] = (current_pc_i==hwlp_end_addr_i[k]) && hwlp_counter_i[k]!=0 && !(hwlp_cnt_we_i && hwlp_regid_i==k).
REQ-020 The block SHALL select the winner as the lowest-index k with match[k]=1 (innermost loop priority); higher indices are ignored that cycle.
REQ-021 The block SHALL drive hwlp_dec_cnt_o = onehot(winner) combinationally only when state==IDLE and pc_valid_i=1 and flush_i=0, and 0 otherwise.
REQ-022 The block SHALL implement an FSM with states IDLE and JUMP_REQ.
REQ-023 In IDLE with a qualified winner whose counter >=2 (unsigned), the block SHALL latch target_q<=hwlp_start_addr_i[winner] and go to JUMP_REQ next cycle.
REQ-024 In IDLE with a qualified winner whose counter ==1, the block SHALL decrement without a jump (loop exit) and stay in IDLE.
REQ-025 In JUMP_REQ the block SHALL assert hwlp_jump_o=1, hwlp_targ_addr_o=target_q and hwlp_stall_o=1, with target_q stable until exit.
REQ-026 In JUMP_REQ, fetch_ack_i=1 SHALL cause a transition to IDLE on the next edge, with a jump latency of 1 cycle minimum from the retire cycle.
REQ-027 In JUMP_REQ, flush_i=1 SHALL cancel the request and return to IDLE next cycle; flush has priority over fetch_ack_i, and the already-issued decrement is not undone.
REQ-028 In JUMP_REQ no new match SHALL be evaluated and hwlp_dec_cnt_o SHALL be 0.
REQ-029 When state==IDLE, hwlp_jump_o=0, hwlp_stall_o=0, and hwlp_targ_addr_o=target_q.
REQ-030 Counter comparisons SHALL be 32-bit unsigned; counter 32'hFFFF_FFFF counts as >=2 (no wrap special case).
REQ-031 When two loops share an end address, only the lowest index SHALL decrement and jump; once it reaches 0, the next index matches.
REQ-032 The block SHALL guarantee $countones(hwlp_dec_cnt_o)<=1 in every cycle; the bench asserts it.

Reset
REQ-033 When rst_n=0 at a posedge, the block SHALL set state<=IDLE and target_q<=32'h0.
REQ-034 Reset SHALL force hwlp_jump_o=0, hwlp_stall_o=0, hwlp_targ_addr_o=0 and hwlp_dec_cnt_o=0 while rst_n=0.
REQ-035 Reset asserted in JUMP_REQ SHALL drop the pending request without requiring fetch_ack_i.

Verification
REQ-036 The bench SHALL drive end[0]=0x100, start[0]=0xF0, cnt[0]=3, pc=0x100, valid=1 -> dec=01, next cycle jump=1, targ=0xF0, stall=1; ack -> IDLE.
REQ-037 The bench SHALL drive the same PC with cnt[0]=1 -> dec=01, jump stays 0 and state stays IDLE.
REQ-038 The bench SHALL set end[0]=end[1]=0x200, cnt[0]=2, cnt[1]=5, pc=0x200 -> dec=01, targ=start[0]; then with cnt[0]=0 -> dec=10, targ=start[1].
REQ-039 The bench SHALL write hwlp_cnt_we_i=1, regid=0 while pc=end[0] and cnt[1] matches -> loop0 is suppressed, dec=10.
REQ-040 The bench SHALL hold JUMP_REQ with fetch_ack_i=0 for 3 cycles -> targ is stable and dec=0; then flush_i=1 together with ack=1 -> IDLE and jump=0 next cycle.
REQ-041 The bench SHALL assert rst_n=0 during JUMP_REQ -> next cycle jump=0, stall=0, targ=0x0.

Source files
------------

// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop sequencer: detects loop-end PCs, issues counter decrements
// and requests a jump back to the loop start until the prefetcher acks.
module riscv_hwloop_sequencer #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                current_pc_i,
    input  logic                       pc_valid_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
    input  logic                       hwlp_cnt_we_i,
    input  logic [N_REG_BITS-1:0]      hwlp_regid_i,
    input  logic                       flush_i,
    input  logic                       fetch_ack_i,
    output logic [N_REGS-1:0]          hwlp_dec_cnt_o,
    output logic                       hwlp_jump_o,
    output logic [31:0]                hwlp_targ_addr_o,
    output logic                       hwlp_stall_o,
    output logic [N_REGS-1:0]          hwlp_active_o
);

    typedef enum logic {
        IDLE,
        JUMP_REQ
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [31:0]           target_q;
    logic [N_REGS-1:0]     match;
    logic                  win_found;
    logic [N_REG_BITS-1:0] win_idx;
    logic                  qualified;
    logic                  jump_take;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            hwlp_active_o[k] = (hwlp_counter_i[k] != 32'd0);
            match[k] = (current_pc_i == hwlp_end_addr_i[k])
                    && (hwlp_counter_i[k] != 32'd0)
                    && !(hwlp_cnt_we_i
                         && hwlp_regid_i == N_REG_BITS'(k));
        end
    end

    // Innermost loop (lowest index) wins when end addresses coincide.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (match[k] && !win_found) begin
                win_found = 1'b1;
                win_idx   = N_REG_BITS'(k);
            end
        end
    end

    assign qualified = rst_n && (state_q == IDLE) && pc_valid_i
                    && !flush_i && win_found;
    assign jump_take = qualified
                    && (hwlp_counter_i[win_idx] > 32'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (jump_take)
                    state_d = JUMP_REQ;
            end
            JUMP_REQ: begin
                if (flush_i || fetch_ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (jump_take)
                target_q <= hwlp_start_addr_i[win_idx];
        end
    end

    // Outputs are forced quiet combinationally while reset is held.
    assign hwlp_dec_cnt_o   = qualified ? (N_REGS'(1) << win_idx) : '0;
    assign hwlp_jump_o      = rst_n && (state_q == JUMP_REQ);
    assign hwlp_stall_o     = rst_n && (state_q == JUMP_REQ);
    assign hwlp_targ_addr_o = rst_n ? target_q : 32'h0;

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Scoreboard bench for riscv_hwloop_sequencer: directed loop scenarios
// followed by randomized traffic against a behavioural loop model.
module tb_riscv_hwloop_sequencer;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       pc;
    logic              pc_valid;
    logic [N-1:0][31:0] st;
    logic [N-1:0][31:0] en;
    logic [N-1:0][31:0] cn;
    logic              we;
    logic [0:0]        regid;
    logic              flush;
    logic              ack;
    logic [N-1:0]      dec;
    logic              jump;
    logic [31:0]       targ;
    logic              stall;
    logic [N-1:0]      active;

    always #5 clk = ~clk;

    riscv_hwloop_sequencer #(.N_REGS(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .current_pc_i      (pc),
        .pc_valid_i        (pc_valid),
        .hwlp_start_addr_i (st),
        .hwlp_end_addr_i   (en),
        .hwlp_counter_i    (cn),
        .hwlp_cnt_we_i     (we),
        .hwlp_regid_i      (regid),
        .flush_i           (flush),
        .fetch_ack_i       (ack),
        .hwlp_dec_cnt_o    (dec),
        .hwlp_jump_o       (jump),
        .hwlp_targ_addr_o  (targ),
        .hwlp_stall_o      (stall),
        .hwlp_active_o     (active)
    );

    typedef struct packed {
        logic [N-1:0] dec;
        logic         jump;
        logic         stall;
        logic [31:0]  targ;
        logic [N-1:0] act;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_pend;
    logic [31:0] m_tgt;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Reference model: expected outputs for the current cycle's inputs,
    // then advance the model's notion of a pending jump.
    task automatic tick();
        exp_t e;
        int   win;
        e   = '0;
        win = -1;
        for (int k = 0; k < N; k++)
            e.act[k] = (cn[k] != 0);
        if (!rst_n) begin
            m_pend = 0;
            m_tgt  = 32'h0;
        end else if (m_pend) begin
            e.jump  = 1'b1;
            e.stall = 1'b1;
            e.targ  = m_tgt;
            if (flush || ack)
                m_pend = 0;
        end else begin
            e.targ = m_tgt;
            for (int k = 0; k < N; k++)
                if (win < 0 && pc == en[k] && cn[k] != 0
                    && !(we && int'(regid) == k))
                    win = k;
            if (win >= 0 && pc_valid && !flush) begin
                e.dec[win] = 1'b1;
                if (cn[win] > 1) begin
                    m_pend = 1;
                    m_tgt  = st[win];
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("dec", 32'(dec), 32'(me.dec));
            chk("jump", 32'(jump), 32'(me.jump));
            chk("stall", 32'(stall), 32'(me.stall));
            chk("targ", targ, me.targ);
            chk("active", 32'(active), 32'(me.act));
            chk("dec_onehot", 32'($countones(dec) <= 1), 32'd1);
        end
    end

    task automatic idle_in();
        pc_valid = 0; flush = 0; ack = 0; we = 0; regid = 0;
    endtask

    initial begin
        rst_n = 0; pc = 0; st = '0; en = '0; cn = '0;
        idle_in();
        m_pend = 0; m_tgt = 0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1;

        // Basic loop back-edge, then ack
        en[0] = 32'h100; st[0] = 32'hF0; cn[0] = 3;
        en[1] = 32'h500; st[1] = 32'h400; cn[1] = 0;
        pc = 32'h100; pc_valid = 1;
        tick();
        idle_in(); cn[0] = 2;
        tick();
        ack = 1;
        tick();
        ack = 0;
        tick();

        // Final iteration: decrement without jump
        cn[0] = 1; pc_valid = 1;
        tick();
        pc_valid = 0; cn[0] = 0;
        tick();

        // Shared end address: innermost wins, then outer
        en[0] = 32'h200; en[1] = 32'h200;
        st[0] = 32'h1F0; st[1] = 32'h180;
        cn[0] = 2; cn[1] = 5; pc = 32'h200; pc_valid = 1;
        tick();
        idle_in(); cn[0] = 1; ack = 1;
        tick();
        ack = 0; cn[0] = 0; pc_valid = 1;
        tick();
        idle_in(); cn[1] = 4; ack = 1;
        tick();
        ack = 0;
        tick();

        // Counter write suppresses loop 0
        en[0] = 32'h300; en[1] = 32'h300;
        cn[0] = 4; cn[1] = 3; pc = 32'h300;
        pc_valid = 1; we = 1; regid = 0;
        tick();
        idle_in(); ack = 1;
        tick();
        ack = 0;
        tick();

        // Held request, then flush together with ack
        cn[0] = 32'hFFFF_FFFF; pc_valid = 1;
        tick();
        idle_in();
        tick();
        tick();
        tick();
        flush = 1; ack = 1;
        tick();
        idle_in();
        tick();

        // Reset while a jump is pending
        cn[0] = 3; pc_valid = 1;
        tick();
        idle_in();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();

        for (int i = 0; i < 600; i++) begin
            logic [31:0] pcs [3];
            pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
            pc = pcs[$urandom_range(0, 2)];
            for (int k = 0; k < N; k++) begin
                en[k] = pcs[$urandom_range(0, 2)];
                st[k] = $urandom;
                cn[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF
                      : 32'($urandom_range(0, 3));
            end
            pc_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            ack      = ($urandom_range(0, 2) == 0);
            we       = ($urandom_range(0, 5) == 0);
            regid    = 1'($urandom_range(0, 1));
            rst_n    = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst_n = 1;
        idle_in();

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
